dma_port_arb: RTL

DMA_PORT_ARB -- requirements
Module: dma_port_arb

---
 rtl/dma_port_arb_pkg.sv | 7 +
 rtl/dma_port_arb_if.sv | 21 ++
 rtl/dma_port_arb_rr_pick.sv | 18 +
 rtl/dma_port_arb.sv | 116 +++++++++++
 4 files changed

// File: rtl/dma_port_arb_pkg.sv
// dma_port_arb_pkg: shared FSM encoding, memory-controller command codes and port grouping
package dma_port_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;
  localparam int NWR = 2;
endpackage

// File: rtl/dma_port_arb_if.sv
// dma_port_arb_if: requester, memory-controller command and beat signals of the arbiter
interface dma_port_arb_if #(parameter int NPORT = 6);
  logic [NPORT-1:0]    req_en;
  logic [NPORT*30-1:0] req_addr;
  logic [NPORT-1:0]    gnt;
  logic                mc_cmd_en;
  logic [2:0]          mc_cmd_instr;
  logic [5:0]          mc_cmd_bl;
  logic [29:0]         mc_cmd_addr;
  logic                mc_cmd_full;
  logic                beat;
  logic                busy;
  modport master (
    output req_en, req_addr, mc_cmd_full, beat,
    input  gnt, mc_cmd_en, mc_cmd_instr, mc_cmd_bl, mc_cmd_addr, busy
  );
  modport slave (
    input  req_en, req_addr, mc_cmd_full, beat,
    output gnt, mc_cmd_en, mc_cmd_instr, mc_cmd_bl, mc_cmd_addr, busy
  );
endinterface

// File: rtl/dma_port_arb_rr_pick.sv
// dma_port_arb_rr_pick: one-hot round-robin pick of the first request after ptr_i
module dma_port_arb_rr_pick #(
  parameter int N = 6,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          valid_o
);
  // scanning from the far end lets the nearest request overwrite earlier hits
  always_comb begin
    pick_o = '0;
    for (int k = N; k >= 1; k--)
      pick_o = req_i[PW'((int'(ptr_i) + k) % N)] ? N'(1) << ((int'(ptr_i) + k) % N) : pick_o;
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/dma_port_arb.sv
// dma_port_arb: round-robin burst arbiter issuing one memory-controller command per grant
// DMA_ARB_WRITE_PRIORITY_EN: write ports 0..1 always beat read ports, each group round-robin
module dma_port_arb
  import dma_port_arb_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int NPORT = 6
) (
  input logic clk,
  input logic rst,
  dma_port_arb_if.slave bus_if
);
  localparam int PW = $clog2(NPORT);
  localparam int CW = $clog2(BURST_LEN) + 1;
  state_e           state_q, state_d;
  logic [NPORT-1:0] gnt_q, gnt_d, pick;
  logic [29:0]      addr_q, addr_d;
  logic [2:0]       instr_q, instr_d;
  logic             en_q, en_d, valid, done;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    win_idx, gnt_idx;
`ifdef DMA_ARB_WRITE_PRIORITY_EN
  localparam int NRD = NPORT - NWR;
  localparam int WW = $clog2(NWR);
  localparam int RW = (NRD > 1) ? $clog2(NRD) : 1;
  logic [WW-1:0]  wptr_q, wptr_d;
  logic [RW-1:0]  rptr_q, rptr_d;
  logic [NWR-1:0] wpick;
  logic [NRD-1:0] rpick;
  logic           wvalid, rvalid;
  dma_port_arb_rr_pick #(.N(NWR)) u_wr_pick (
    .req_i(bus_if.req_en[NWR-1:0]), .ptr_i(wptr_q), .pick_o(wpick), .valid_o(wvalid)
  );
  dma_port_arb_rr_pick #(.N(NRD)) u_rd_pick (
    .req_i(bus_if.req_en[NPORT-1:NWR]), .ptr_i(rptr_q), .pick_o(rpick), .valid_o(rvalid)
  );
  assign pick   = wvalid ? {{NRD{1'b0}}, wpick} : {rpick, {NWR{1'b0}}};
  assign valid  = wvalid | rvalid;
  assign wptr_d = done && gnt_idx < PW'(NWR) ? WW'(gnt_idx) : wptr_q;
  assign rptr_d = done && gnt_idx >= PW'(NWR) ? RW'(gnt_idx - PW'(NWR)) : rptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= WW'(NWR - 1);
      rptr_q <= RW'(NRD - 1);
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
`else
  logic [PW-1:0] ptr_q, ptr_d;
  dma_port_arb_rr_pick #(.N(NPORT)) u_pick (
    .req_i(bus_if.req_en), .ptr_i(ptr_q), .pick_o(pick), .valid_o(valid)
  );
  assign ptr_d = done ? gnt_idx : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= PW'(NPORT - 1);
    else ptr_q <= ptr_d;
`endif
  always_comb begin
    win_idx = '0;
    gnt_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      win_idx = pick[i] ? PW'(i) : win_idx;
      gnt_idx = gnt_q[i] ? PW'(i) : gnt_idx;
    end
  end
  assign done = state_q == WAIT && bus_if.beat && cnt_q == CW'(BURST_LEN - 1);
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    case (state_q)
      IDLE: if (valid) begin
        state_d = ISSUE;
        gnt_d   = pick;
        addr_d  = bus_if.req_addr[30*int'(win_idx) +: 30];
        instr_d = win_idx < PW'(NWR) ? INSTR_WR : INSTR_RD;
      end
      ISSUE: if (!bus_if.mc_cmd_full) begin
        state_d = WAIT;
        en_d    = 1'b1;
      end
      WAIT: if (bus_if.beat) begin
        state_d = done ? IDLE : WAIT;
        gnt_d   = done ? '0 : gnt_q;
        cnt_d   = done ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= INSTR_WR;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  assign bus_if.gnt          = gnt_q;
  assign bus_if.mc_cmd_en    = en_q;
  assign bus_if.mc_cmd_instr = instr_q;
  assign bus_if.mc_cmd_addr  = addr_q;
  assign bus_if.mc_cmd_bl    = 6'(BURST_LEN - 1);
  assign bus_if.busy         = state_q != IDLE;
endmodule
